// File: rtl/id_ex_pipe_reg.sv
// Decode->execute pipeline register with valid/ready handshake, flush and optional 2-entry skid stage.
// Define ID_EX_REG_PERF_EN to add saturating stall/bubble performance counters.
module id_ex_pipe_reg #(
   parameter int DW    = 96,
   parameter int SKID  = 1,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DW-1:0]    out_data
`ifdef ID_EX_REG_PERF_EN
   ,
   output logic [CNT_W-1:0] perf_stall_cnt,
   output logic [CNT_W-1:0] perf_bubble_cnt
`endif
);

   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic          accept;
   logic          deliver;

   assign accept    = in_valid & in_ready;
   assign deliver   = out_valid_q & out_ready;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   generate
      if (SKID != 0) begin : g_skid
         localparam logic [1:0] ST_EMPTY = 2'b00;
         localparam logic [1:0] ST_ONE   = 2'b01;
         localparam logic [1:0] ST_TWO   = 2'b11;

         logic          skid_valid_q, skid_valid_d;
         logic [DW-1:0] skid_data_q, skid_data_d;
         logic [1:0]    state;

         // The skid flag doubles as the FSM's upper state bit, so in_ready is a pure flop output.
         assign state    = {skid_valid_q, out_valid_q};
         assign in_ready = ~skid_valid_q;

         always_comb begin
            out_valid_d  = out_valid_q;
            out_data_d   = out_data_q;
            skid_valid_d = skid_valid_q;
            skid_data_d  = skid_data_q;
            if (flush) begin
               out_valid_d  = 1'b0;
               skid_valid_d = 1'b0;
            end else begin
               case (state)
                  ST_EMPTY: begin
                     if (accept) begin
                        out_valid_d = 1'b1;
                        out_data_d  = in_data;
                     end
                  end
                  ST_ONE: begin
                     if (accept && deliver) begin
                        out_data_d = in_data;
                     end else if (accept) begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = in_data;
                     end else if (deliver) begin
                        out_valid_d = 1'b0;
                     end
                  end
                  ST_TWO: begin
                     if (deliver) begin
                        out_data_d   = skid_data_q;
                        skid_valid_d = 1'b0;
                     end
                  end
                  default: begin
                  end
               endcase
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               skid_valid_q <= 1'b0;
               skid_data_q  <= '0;
            end else begin
               skid_valid_q <= skid_valid_d;
               skid_data_q  <= skid_data_d;
            end
         end
      end else begin : g_single
         assign in_ready = ~out_valid_q | out_ready;

         always_comb begin
            out_valid_d = out_valid_q;
            out_data_d  = out_data_q;
            if (flush) begin
               out_valid_d = 1'b0;
            end else if (accept) begin
               out_valid_d = 1'b1;
               out_data_d  = in_data;
            end else if (deliver) begin
               out_valid_d = 1'b0;
            end
         end
      end
   endgenerate

`ifdef ID_EX_REG_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] bubble_cnt_q;

   assign perf_stall_cnt  = stall_cnt_q;
   assign perf_bubble_cnt = bubble_cnt_q;

   // Saturating counters; flush deliberately leaves them alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (!out_valid_q && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
         end
      end
   end
`else
   logic unused_cnt_w;
   assign unused_cnt_w = (CNT_W != 0);
`endif

endmodule
